// File: rtl/ram_burst_master_if.sv
// Command, write-stream, read-stream and RAM pin bundle for ram_burst_master.
// The master modport is the burst engine's view; slave is the surrounding system's view.
`timescale 1ns/1ps
interface ram_burst_master_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;

    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    logic              done;
    logic              busy;

    logic [ADDR_W-1:0] ram_add;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_r_w;
    logic              ram_enable;
    logic [DATA_W-1:0] ram_data_out;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  ram_data_out,
        output cmd_ready, wr_ready, rd_valid, rd_data, done, busy,
        output ram_add, ram_data_in, ram_r_w, ram_enable
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output ram_data_out,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done, busy,
        input  ram_add, ram_data_in, ram_r_w, ram_enable
    );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port RAM with 1-cycle registered read.
// One read or write burst at a time; address counter wraps modulo the RAM depth.
`timescale 1ns/1ps
module ram_burst_master #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    ram_burst_master_if.master    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_beats;
    logic              r_rd_valid;
    logic              r_done;
    logic              r_busy;

    logic              w_accept;
    logic              w_beat;
    logic              w_last;
    logic              w_rd_issue;
    logic [DATA_W-1:0] w_wr_word;

    // Next state plus all ce-qualified strobes; reset masks the RAM pins and handshakes.
    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_beat         = 1'b0;
        w_rd_issue     = 1'b0;
        bus.cmd_ready  = 1'b0;
        bus.wr_ready   = 1'b0;
        bus.ram_enable = 1'b0;
        bus.ram_r_w    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                bus.cmd_ready = ce;
                w_accept      = ce & bus.cmd_valid;
                if (w_accept) begin
                    w_state_next = bus.cmd_write ? S_WR : S_RD;
                end
            end
            S_WR: begin
                bus.wr_ready   = ce;
                bus.ram_r_w    = 1'b1;
                bus.ram_enable = ce & bus.wr_valid;
                w_beat         = ce & bus.wr_valid;
            end
            S_RD: begin
                bus.ram_enable = ce;
                w_beat         = ce;
                w_rd_issue     = ce;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_last = w_beat && (r_beats == '0);
        if (w_last) begin
            w_state_next = S_IDLE;
        end

        if (reset) begin
            bus.cmd_ready  = 1'b0;
            bus.wr_ready   = 1'b0;
            bus.ram_enable = 1'b0;
            bus.ram_r_w    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (ce) begin
            r_state <= w_state_next;
        end
    end

    // Counters and registered strobes all freeze while ce is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_beats    <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else if (ce) begin
            r_rd_valid <= w_rd_issue;
            r_done     <= w_last;
            if (w_accept) begin
                r_addr  <= bus.cmd_addr;
                r_beats <= bus.cmd_len;
                r_busy  <= 1'b1;
            end else if (w_beat) begin
                r_addr  <= r_addr + 1'b1;
                r_beats <= r_beats - 1'b1;
                if (w_last) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign w_wr_word       = bus.wr_data;
    assign bus.ram_data_in = w_wr_word;
    assign bus.ram_add     = reset ? '0 : r_addr;
    assign bus.rd_data     = bus.ram_data_out;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.done        = r_done;
    assign bus.busy        = r_busy;
endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Initiator for the 64×16 single-port data RAM.
- Accepts one read or write burst command at a time and drives the RAM's address, data, r_w and enable pins.
- Streams write data in with a valid/ready handshake and streams read data out.
- Pulses `done` when a burst completes.
- Sits between the CPU/loader side and the RAM. It shares the global `ce` clock enable with the RAM.

## Interface
Parameters:
- `ADDR_W`, 6, RAM address width; depth 2^ADDR_W, addresses wrap modulo depth
- `DATA_W`, 16, RAM word width

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `ce`  in  1  global clock enable, also wired to the RAM `ce`
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  block idle, command accepted on `cmd_valid & cmd_ready & ce`
- `cmd_write`  in  1  1 = write burst, 0 = read burst
- `cmd_addr`  in  ADDR_W  start address
- `cmd_len`  in  ADDR_W  beats minus 1; 0 = 1 beat, 63 = 64 beats
- `wr_valid`  in  1  write beat available
- `wr_data`  in  DATA_W  write beat
- `wr_ready`  out  1  write beat consumed on `wr_valid & wr_ready & ce`
- `rd_valid`  out  1  `rd_data` valid; no backpressure
- `rd_data`  out  DATA_W  read beat, driven directly from `ram_data_out`
- `done`  out  1  one-cycle completion pulse
- `busy`  out  1  burst in progress
- `ram_add`  out  ADDR_W  to RAM `add`
- `ram_data_in`  out  DATA_W  to RAM `data_in`
- `ram_r_w`  out  1  to RAM `r_w`; 1 = write, 0 = read
- `ram_enable`  out  1  to RAM `enable`
- `ram_data_out`  in  DATA_W  from RAM `data_out`; registered in the RAM with 1-cycle read latency

## Operation
- **States:** IDLE, WR, RD.
- **Reset:** synchronous. It has priority over `ce`.
  - Forces IDLE.
  - Clears `rd_valid`, `done`, `busy` and the address/beat counters.
  - Sets `cmd_ready` = 1 from the first cycle after reset deasserts.
  - `ram_enable` = 0, `ram_r_w` = 0, `ram_add` = 0, `wr_ready` = 0.
- **IDLE:**
  - `cmd_ready` = `ce`.
  - On acceptance, latch `cmd_addr` into the address counter and `cmd_len` into the beat counter.
  - Go to WR if `cmd_write` = 1, else RD. Set `busy`.
- **WR:**
  - `wr_ready` = `ce`. `ram_enable` = `wr_valid & ce`, `ram_r_w` = 1.
  - `ram_add` = address counter, `ram_data_in` = `wr_data`. These are combinational, so each beat is written on its handshake edge.
  - Each beat increments the address counter modulo 2^ADDR_W and decrements the beat counter.
  - A beat with the beat counter = 0 is the last; go to IDLE.
  - Gaps in `wr_valid` stall the burst with no RAM access.
- **RD:**
  - `ram_enable` = `ce`, `ram_r_w` = 0.
  - One read is issued per `ce` cycle. Address and beat counters update as in WR.
  - After the last issue, go to IDLE.
  - `rd_valid` is registered: set on the edge after each issue.
- **`done`:** registered. Asserted for the single cycle following the edge of the final RAM access, in both WR and RD. `busy` clears on that same edge.
- **`ce` = 0:**
  - All state, counters, `rd_valid` and `done` hold.
  - `cmd_ready`, `wr_ready` and `ram_enable` are 0.
  - Sinks qualify `rd_valid` and `done` with `ce`.
- **Reset mid-burst:** the burst is abandoned with no `done` pulse. Any read data in flight is dropped and `rd_valid` = 0.
- **Command during a burst:** not accepted, because `cmd_ready` = 0. `cmd_*` is don't-care outside acceptance.

## Timing
All cycles below assume `ce` = 1.
- **Command accepted on edge N, length L = `cmd_len` + 1:**
  - Read: RAM reads on edges N+1 … N+L. `rd_valid` is high in cycles N+2 … N+L+1. `done` is high in cycle N+L+1, coincident with the last `rd_valid`.
  - `cmd_ready` is high again in cycle N+L+1. A new command can be accepted there, so back-to-back bursts have exactly one bubble cycle.
  - Write with `wr_valid` held high: RAM writes on edges N+1 … N+L. `done` and `cmd_ready` are high in cycle N+L+1.
- **Wrap-around:** the address counter wraps 63 → 0 with no other effect.
- **Read-after-write:** a read issued the cycle after a write completes returns the new data. The RAM writes on the edge, and the read occurs a later edge.

## Test plan
- **Reset:** assert `reset` 2 cycles with `ce` = 1 → `cmd_ready` = 1, `busy`/`done`/`rd_valid`/`ram_enable` = 0, `ram_add` = 0.
- **Write then read:**
  - Write burst addr 10, len 3, data 0xA000..0xA003, with `wr_valid` low for 1 cycle after beat 1 → RAM[10..13] = 0xA000..0xA003; `done` one cycle after beat 3.
  - Then read burst addr 10, len 3 → `rd_data` 0xA000..0xA003 on 4 consecutive `rd_valid` cycles; `done` on the 4th.
- **Wrap:** write addr 62, len 2, data 1, 2, 3 → RAM[62] = 1, RAM[63] = 2, RAM[0] = 3; read back addr 62, len 2 returns 1, 2, 3.
- **`ce` stall:** read addr 0, len 7 with `ce` = 0 for 3 cycles after beat 2 → `ram_enable` = 0 during the stall; 8 beats returned in order with no duplicates; `done` once.
- **Reset mid-burst:** reset in the 3rd cycle of a 16-beat read → next cycle IDLE, `rd_valid` = 0, no `done`; a subsequent 1-beat read (len 0) completes normally.
- **Back-to-back:** write len 0 at addr 5 (data 0x55AA), then a read command held valid → read accepted the cycle `done` is high; returns 0x55AA.
